// File: rtl/ysyx_24090018_wbu.sv
// ---------------------------------------------------------------------------
// ysyx_24090018_wbu -- writeback unit
//
// Collects results from the ALU (EXU) and the load unit (LSU) into one-entry
// holding buffers, picks one buffer per cycle to drive the register-file
// write port, and keeps a busy scoreboard of destinations with outstanding
// writes so decode can detect hazards on its source operands.
//
// Ports
//   clk, rst_n                         clock, asynchronous active-low reset
//   exu_valid/exu_ready                ALU result handshake
//   exu_wen, exu_rd, exu_wdata         ALU write enable, destination, value
//   lsu_valid/lsu_ready                load result handshake
//   lsu_wen, lsu_rd, lsu_wdata         load write enable, destination, value
//   alloc_valid, alloc_rd              issue marks a destination as pending
//   rs1, rs2 / rs1_busy, rs2_busy      decode source query and busy answer
//   rf_wen, rf_waddr, rf_wdata         register-file write port
//
// Only address bits [3:0] are meaningful (16 registers, RV32E); x0 is never
// written and never reported busy.
// ---------------------------------------------------------------------------
module ysyx_24090018_wbu #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  exu_valid,
  output logic                  exu_ready,
  input  logic                  exu_wen,
  input  logic [ADDR_WIDTH-1:0] exu_rd,
  input  logic [DATA_WIDTH-1:0] exu_wdata,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic                  lsu_wen,
  input  logic [ADDR_WIDTH-1:0] lsu_rd,
  input  logic [DATA_WIDTH-1:0] lsu_wdata,
  input  logic                  alloc_valid,
  input  logic [ADDR_WIDTH-1:0] alloc_rd,
  input  logic [ADDR_WIDTH-1:0] rs1,
  input  logic [ADDR_WIDTH-1:0] rs2,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata
);

  logic                  exuFull_q, exuFull_d;
  logic                  exuWen_q, exuWen_d;
  logic [ADDR_WIDTH-1:0] exuRd_q, exuRd_d;
  logic [DATA_WIDTH-1:0] exuWdata_q, exuWdata_d;
  logic                  lsuFull_q, lsuFull_d;
  logic                  lsuWen_q, lsuWen_d;
  logic [ADDR_WIDTH-1:0] lsuRd_q, lsuRd_d;
  logic [DATA_WIDTH-1:0] lsuWdata_q, lsuWdata_d;
  logic                  lastLsu_q, lastLsu_d;
  logic [15:0]           busy_q, busy_d;

  logic grantExu, grantLsu;
  logic exuHs, lsuHs;

  // Bit [4] of every address only exists for the RV32I-sized port width.
  logic unusedAddrBits;
  assign unusedAddrBits = ^{alloc_rd, rs1, rs2};

  // A lone full buffer always wins; with both full, the source that did not
  // win last time goes next (lastLsu_q=0 after reset, so LSU wins first).
  always_comb begin
    grantExu = exuFull_q && (!lsuFull_q || lastLsu_q);
    grantLsu = lsuFull_q && (!exuFull_q || !lastLsu_q);
  end

  // A buffer can accept when empty or when it is draining this same cycle,
  // which lets each source stream one result per cycle.
  always_comb begin
    exu_ready = !exuFull_q || grantExu;
    lsu_ready = !lsuFull_q || grantLsu;
    exuHs     = exu_valid && exu_ready;
    lsuHs     = lsu_valid && lsu_ready;
  end

  // Register-file port follows the granted buffer; writes to x0 and wen=0
  // entries still drain but never raise rf_wen.
  always_comb begin
    rf_wen   = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    if (grantExu) begin
      rf_wen   = exuWen_q && (exuRd_q[3:0] != 4'd0);
      rf_waddr = exuRd_q;
      rf_wdata = exuWdata_q;
    end else if (grantLsu) begin
      rf_wen   = lsuWen_q && (lsuRd_q[3:0] != 4'd0);
      rf_waddr = lsuRd_q;
      rf_wdata = lsuWdata_q;
    end
  end

  // Buffer next state: a handshake loads (and wins over a same-cycle drain),
  // otherwise a grant empties the buffer.
  always_comb begin
    exuFull_d  = exuHs || (exuFull_q && !grantExu);
    exuWen_d   = exuHs ? exu_wen   : exuWen_q;
    exuRd_d    = exuHs ? exu_rd    : exuRd_q;
    exuWdata_d = exuHs ? exu_wdata : exuWdata_q;
    lsuFull_d  = lsuHs || (lsuFull_q && !grantLsu);
    lsuWen_d   = lsuHs ? lsu_wen   : lsuWen_q;
    lsuRd_d    = lsuHs ? lsu_rd    : lsuRd_q;
    lsuWdata_d = lsuHs ? lsu_wdata : lsuWdata_q;
    lastLsu_d  = (grantExu || grantLsu) ? grantLsu : lastLsu_q;
  end

  // Scoreboard: writeback clears first so a same-cycle allocation of the
  // same register leaves it busy; x0 is pinned to not-busy.
  always_comb begin
    busy_d = busy_q;
    if (rf_wen) busy_d[rf_waddr[3:0]] = 1'b0;
    if (alloc_valid) busy_d[alloc_rd[3:0]] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_comb begin
    rs1_busy = (rs1[3:0] != 4'd0) && busy_q[rs1[3:0]];
    rs2_busy = (rs2[3:0] != 4'd0) && busy_q[rs2[3:0]];
  end

  // All state clears the instant reset asserts, discarding buffered results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exuFull_q  <= 1'b0;
      exuWen_q   <= 1'b0;
      exuRd_q    <= '0;
      exuWdata_q <= '0;
      lsuFull_q  <= 1'b0;
      lsuWen_q   <= 1'b0;
      lsuRd_q    <= '0;
      lsuWdata_q <= '0;
      lastLsu_q  <= 1'b0;
      busy_q     <= '0;
    end else begin
      exuFull_q  <= exuFull_d;
      exuWen_q   <= exuWen_d;
      exuRd_q    <= exuRd_d;
      exuWdata_q <= exuWdata_d;
      lsuFull_q  <= lsuFull_d;
      lsuWen_q   <= lsuWen_d;
      lsuRd_q    <= lsuRd_d;
      lsuWdata_q <= lsuWdata_d;
      lastLsu_q  <= lastLsu_d;
      busy_q     <= busy_d;
    end
  end

endmodule

// File: tb/tb_ysyx_24090018_wbu.sv
// ---------------------------------------------------------------------------
// tb_ysyx_24090018_wbu -- directed self-checking bench for the writeback unit.
// Inputs change 1 ns after each rising edge; outputs are sampled 2 ns after.
// ---------------------------------------------------------------------------
module tb_ysyx_24090018_wbu;

  logic        clk;
  logic        rst_n;
  logic        exu_valid, exu_ready, exu_wen;
  logic [4:0]  exu_rd;
  logic [31:0] exu_wdata;
  logic        lsu_valid, lsu_ready, lsu_wen;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_wdata;
  logic        alloc_valid;
  logic [4:0]  alloc_rd, rs1, rs2;
  logic        rs1_busy, rs2_busy;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  int compared = 0;
  int mismatched = 0;

  ysyx_24090018_wbu #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .exu_valid(exu_valid), .exu_ready(exu_ready), .exu_wen(exu_wen),
    .exu_rd(exu_rd), .exu_wdata(exu_wdata),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_wen(lsu_wen),
    .lsu_rd(lsu_rd), .lsu_wdata(lsu_wdata),
    .alloc_valid(alloc_valid), .alloc_rd(alloc_rd),
    .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    exu_valid = 0; exu_wen = 0; exu_rd = 0; exu_wdata = 0;
    lsu_valid = 0; lsu_wen = 0; lsu_rd = 0; lsu_wdata = 0;
    alloc_valid = 0; alloc_rd = 0; rs1 = 5'd5; rs2 = 5'd9;
    #2;
    compared++; if (exu_ready !== 1'b1) begin mismatched++; $display("FAIL reset_exu_ready got=%0b exp=1", exu_ready); end
    compared++; if (lsu_ready !== 1'b1) begin mismatched++; $display("FAIL reset_lsu_ready got=%0b exp=1", lsu_ready); end
    compared++; if (rf_wen !== 1'b0) begin mismatched++; $display("FAIL reset_rf_wen got=%0b exp=0", rf_wen); end
    compared++; if (rf_waddr !== 5'd0) begin mismatched++; $display("FAIL reset_rf_waddr got=%0h exp=0", rf_waddr); end
    compared++; if (rf_wdata !== 32'd0) begin mismatched++; $display("FAIL reset_rf_wdata got=%0h exp=0", rf_wdata); end
    compared++; if ({rs1_busy, rs2_busy} !== 2'b00) begin mismatched++; $display("FAIL reset_rs_busy got=%b exp=00", {rs1_busy, rs2_busy}); end
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Alloc x5, then one EXU write of 0xDEADBEEF to x5.
  task automatic test_single_write();
    alloc_valid = 1; alloc_rd = 5'd5; rs1 = 5'd5;
    tick();
    alloc_valid = 0;
    #1;
    compared++; if (rs1_busy !== 1'b1) begin mismatched++; $display("FAIL single_busy_set got=%0b exp=1", rs1_busy); end
    exu_valid = 1; exu_wen = 1; exu_rd = 5'd5; exu_wdata = 32'hDEADBEEF;
    #1;
    compared++; if (exu_ready !== 1'b1) begin mismatched++; $display("FAIL single_ready got=%0b exp=1", exu_ready); end
    compared++; if (rf_wen !== 1'b0) begin mismatched++; $display("FAIL single_early_wen got=%0b exp=0", rf_wen); end
    tick();
    exu_valid = 0;
    #1;
    compared++; if (rf_wen !== 1'b1) begin mismatched++; $display("FAIL single_wen got=%0b exp=1", rf_wen); end
    compared++; if (rf_waddr !== 5'd5) begin mismatched++; $display("FAIL single_waddr got=%0d exp=5", rf_waddr); end
    compared++; if (rf_wdata !== 32'hDEADBEEF) begin mismatched++; $display("FAIL single_wdata got=%0h exp=deadbeef", rf_wdata); end
    compared++; if (rs1_busy !== 1'b1) begin mismatched++; $display("FAIL single_busy_grant got=%0b exp=1", rs1_busy); end
    tick();
    #1;
    compared++; if (rf_wen !== 1'b0) begin mismatched++; $display("FAIL single_wen_after got=%0b exp=0", rf_wen); end
    compared++; if (rs1_busy !== 1'b0) begin mismatched++; $display("FAIL single_busy_clear got=%0b exp=0", rs1_busy); end
    compared++; if (rf_wdata !== 32'd0) begin mismatched++; $display("FAIL single_idle_wdata got=%0h exp=0", rf_wdata); end
  endtask

  // Both sources offer four results; grants alternate starting with LSU.
  task automatic test_contention();
    int expRd [10];
    int expExuRdy [10];
    int expLsuRdy [10];
    int ei = 0;
    int li = 0;
    logic eh, lh;
    expRd     = '{0, 9, 1, 10, 2, 11, 3, 12, 4, 0};
    expExuRdy = '{1, 0, 1, 0, 1, 0, 1, 0, 1, 1};
    expLsuRdy = '{1, 1, 0, 1, 0, 1, 0, 1, 1, 1};
    exu_wen = 1; lsu_wen = 1;
    for (int c = 0; c < 10; c++) begin
      exu_valid = (ei < 4); exu_rd = 5'(1 + ei); exu_wdata = 32'(32'h100 + 1 + ei);
      lsu_valid = (li < 4); lsu_rd = 5'(9 + li); lsu_wdata = 32'(32'h100 + 9 + li);
      #1;
      compared++; if (rf_wen !== (expRd[c] != 0)) begin mismatched++; $display("FAIL cont_wen c=%0d got=%0b exp=%0b", c, rf_wen, expRd[c] != 0); end
      compared++; if (rf_waddr !== 5'(expRd[c])) begin mismatched++; $display("FAIL cont_waddr c=%0d got=%0d exp=%0d", c, rf_waddr, expRd[c]); end
      if (expRd[c] != 0) begin
        compared++; if (rf_wdata !== 32'(32'h100 + expRd[c])) begin mismatched++; $display("FAIL cont_wdata c=%0d got=%0h exp=%0h", c, rf_wdata, 32'h100 + expRd[c]); end
      end
      compared++; if (exu_ready !== expExuRdy[c][0]) begin mismatched++; $display("FAIL cont_exu_ready c=%0d got=%0b exp=%0d", c, exu_ready, expExuRdy[c]); end
      compared++; if (lsu_ready !== expLsuRdy[c][0]) begin mismatched++; $display("FAIL cont_lsu_ready c=%0d got=%0b exp=%0d", c, lsu_ready, expLsuRdy[c]); end
      eh = exu_valid && exu_ready;
      lh = lsu_valid && lsu_ready;
      tick();
      if (eh) ei++;
      if (lh) li++;
    end
    exu_valid = 0; lsu_valid = 0;
    compared++; if (ei + li !== 8) begin mismatched++; $display("FAIL cont_accepted got=%0d exp=8", ei + li); end
  endtask

  // Writes to x0 and a wen=0 load both drain without touching the file.
  task automatic test_x0_wen0();
    exu_valid = 1; exu_wen = 1; exu_rd = 5'd0; exu_wdata = 32'h1234;
    alloc_valid = 1; alloc_rd = 5'h10; rs1 = 5'h10;
    tick();
    exu_valid = 0; alloc_valid = 0;
    lsu_valid = 1; lsu_wen = 0; lsu_rd = 5'd7; lsu_wdata = 32'h55;
    #1;
    compared++; if (rs1_busy !== 1'b0) begin mismatched++; $display("FAIL x0_busy got=%0b exp=0", rs1_busy); end
    compared++; if (rf_wen !== 1'b0) begin mismatched++; $display("FAIL x0_wen got=%0b exp=0", rf_wen); end
    compared++; if (rf_wdata !== 32'h1234) begin mismatched++; $display("FAIL x0_wdata got=%0h exp=1234", rf_wdata); end
    compared++; if (lsu_ready !== 1'b1) begin mismatched++; $display("FAIL x0_lsu_ready got=%0b exp=1", lsu_ready); end
    tick();
    lsu_valid = 0;
    #1;
    compared++; if (rf_wen !== 1'b0) begin mismatched++; $display("FAIL wen0_wen got=%0b exp=0", rf_wen); end
    compared++; if (rf_waddr !== 5'd7) begin mismatched++; $display("FAIL wen0_waddr got=%0d exp=7", rf_waddr); end
    compared++; if (rf_wdata !== 32'h55) begin mismatched++; $display("FAIL wen0_wdata got=%0h exp=55", rf_wdata); end
    compared++; if (exu_ready !== 1'b1) begin mismatched++; $display("FAIL x0_exu_drained got=%0b exp=1", exu_ready); end
    tick();
    #1;
    compared++; if (rf_waddr !== 5'd0) begin mismatched++; $display("FAIL wen0_idle_waddr got=%0d exp=0", rf_waddr); end
    compared++; if (rs1_busy !== 1'b0) begin mismatched++; $display("FAIL x0_busy_end got=%0b exp=0", rs1_busy); end
  endtask

  // Allocation and writeback of x3 in the same cycle leaves x3 busy; a
  // later write addressed as 0x13 (bit 4 ignored) clears it.
  task automatic test_set_vs_clear();
    alloc_valid = 1; alloc_rd = 5'd3; rs2 = 5'd3;
    tick();
    alloc_valid = 0;
    exu_valid = 1; exu_wen = 1; exu_rd = 5'd3; exu_wdata = 32'h33;
    tick();
    exu_valid = 0;
    alloc_valid = 1; alloc_rd = 5'd3;
    #1;
    compared++; if (rf_wen !== 1'b1) begin mismatched++; $display("FAIL svc_wen got=%0b exp=1", rf_wen); end
    compared++; if (rf_waddr !== 5'd3) begin mismatched++; $display("FAIL svc_waddr got=%0d exp=3", rf_waddr); end
    tick();
    alloc_valid = 0;
    #1;
    compared++; if (rs2_busy !== 1'b1) begin mismatched++; $display("FAIL svc_set_wins got=%0b exp=1", rs2_busy); end
    lsu_valid = 1; lsu_wen = 1; lsu_rd = 5'h13; lsu_wdata = 32'h44;
    tick();
    lsu_valid = 0;
    #1;
    compared++; if (rf_wen !== 1'b1) begin mismatched++; $display("FAIL svc_wen2 got=%0b exp=1", rf_wen); end
    compared++; if (rs2_busy !== 1'b1) begin mismatched++; $display("FAIL svc_busy_pending got=%0b exp=1", rs2_busy); end
    tick();
    #1;
    compared++; if (rs2_busy !== 1'b0) begin mismatched++; $display("FAIL svc_busy_clear got=%0b exp=0", rs2_busy); end
  endtask

  // EXU streams 16 results back to back with LSU idle.
  task automatic test_back_to_back();
    exu_wen = 1;
    for (int c = 0; c < 18; c++) begin
      exu_valid = (c < 16); exu_rd = 5'(1 + (c % 15)); exu_wdata = 32'(c);
      #1;
      if (c < 16) begin
        compared++; if (exu_ready !== 1'b1) begin mismatched++; $display("FAIL stream_ready c=%0d got=%0b exp=1", c, exu_ready); end
      end
      if (c >= 1 && c <= 16) begin
        compared++; if (rf_wen !== 1'b1) begin mismatched++; $display("FAIL stream_wen c=%0d got=%0b exp=1", c, rf_wen); end
        compared++; if (rf_wdata !== 32'(c - 1)) begin mismatched++; $display("FAIL stream_wdata c=%0d got=%0d exp=%0d", c, rf_wdata, c - 1); end
      end
      if (c == 17) begin
        compared++; if (rf_wen !== 1'b0) begin mismatched++; $display("FAIL stream_end_wen got=%0b exp=0", rf_wen); end
      end
      tick();
    end
    exu_valid = 0;
  endtask

  // Reset mid-cycle with both buffers full and busy=0xFFFE.
  task automatic test_async_reset();
    for (int r = 1; r < 16; r++) begin
      alloc_valid = 1; alloc_rd = 5'(r);
      tick();
    end
    alloc_valid = 0;
    rs1 = 5'd15; rs2 = 5'd1;
    #1;
    compared++; if ({rs1_busy, rs2_busy} !== 2'b11) begin mismatched++; $display("FAIL ar_busy_filled got=%b exp=11", {rs1_busy, rs2_busy}); end
    exu_valid = 1; exu_wen = 1; exu_rd = 5'd2; exu_wdata = 32'hA2;
    lsu_valid = 1; lsu_wen = 1; lsu_rd = 5'd3; lsu_wdata = 32'hB3;
    tick();
    exu_valid = 0; lsu_valid = 0;
    #1;
    compared++; if (rf_wen !== 1'b1) begin mismatched++; $display("FAIL ar_pre_wen got=%0b exp=1", rf_wen); end
    #1;
    rst_n = 1'b0;
    #1;
    compared++; if ({exu_ready, lsu_ready} !== 2'b11) begin mismatched++; $display("FAIL ar_ready got=%b exp=11", {exu_ready, lsu_ready}); end
    compared++; if (rf_wen !== 1'b0) begin mismatched++; $display("FAIL ar_wen got=%0b exp=0", rf_wen); end
    compared++; if (rf_waddr !== 5'd0) begin mismatched++; $display("FAIL ar_waddr got=%0d exp=0", rf_waddr); end
    compared++; if (rf_wdata !== 32'd0) begin mismatched++; $display("FAIL ar_wdata got=%0h exp=0", rf_wdata); end
    compared++; if ({rs1_busy, rs2_busy} !== 2'b00) begin mismatched++; $display("FAIL ar_busy got=%b exp=00", {rs1_busy, rs2_busy}); end
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      compared++; if (rf_wen !== 1'b0) begin mismatched++; $display("FAIL ar_no_pulse c=%0d got=%0b exp=0", c, rf_wen); end
      tick();
    end
    compared++; if (rs1_busy !== 1'b0) begin mismatched++; $display("FAIL ar_busy_after got=%0b exp=0", rs1_busy); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_contention();
    test_x0_wen0();
    test_set_vs_clear();
    test_back_to_back();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
